// File: rtl/led_pkg.sv
// led_pkg: keyframe and state types, tick defaults and the per-channel
// linear interpolation shared by the LED fade sequencer.
package led_pkg;

    localparam int CLK_FREQ_DEFAULT = 12_000_000;
    localparam int TICK_HZ_DEFAULT  = 1000;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
        logic [7:0] fade;
        logic [7:0] hold;
    } keyframe_t;

    typedef enum logic [1:0] {IDLE, LOAD, FADE, HOLD} state_e;

    // start + (target - start) * step / fade, signed division truncates toward zero
    function automatic logic [7:0] interp(input logic [7:0] s, input logic [7:0] t,
                                          input logic [7:0] step, input logic [7:0] fade);
        logic signed [8:0]  d;
        logic signed [16:0] p;
        d = $signed({1'b0, t}) - $signed({1'b0, s});
        p = 17'(d) * 17'($signed({1'b0, step}));
        return 8'(17'($signed({1'b0, s})) + p / 17'($signed({1'b0, fade})));
    endfunction

endpackage

// File: rtl/led_fade_sequencer_if.sv
// led_fade_sequencer_if: keyframe write port, sequence control and the
// three duty-cycle outputs; master drives, slave is the sequencer.
interface led_fade_sequencer_if #(parameter int DEPTH = 8);

    localparam int AW = $clog2(DEPTH);

    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_red;
    logic [7:0]    wr_green;
    logic [7:0]    wr_blue;
    logic [7:0]    wr_fade;
    logic [7:0]    wr_hold;
    logic [AW:0]   count;
    logic          loop;
    logic          start;
    logic          stop;
    logic          busy;
    logic [AW-1:0] cur_index;
    logic          seq_done;
    logic [7:0]    red_duty;
    logic [7:0]    green_duty;
    logic [7:0]    blue_duty;

    modport master (
        output wr_valid, wr_addr, wr_red, wr_green, wr_blue, wr_fade, wr_hold,
               count, loop, start, stop,
        input  wr_ready, busy, cur_index, seq_done, red_duty, green_duty, blue_duty
    );

    modport slave (
        input  wr_valid, wr_addr, wr_red, wr_green, wr_blue, wr_fade, wr_hold,
               count, loop, start, stop,
        output wr_ready, busy, cur_index, seq_done, red_duty, green_duty, blue_duty
    );

endinterface

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running modulo-CYCLES counter with a one-cycle tick
// on the last count and a synchronous clear.
module led_tick_gen #(
    parameter int CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == CW'(CYCLES - 1);

    always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

endmodule

// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer: steps through a table of RGB keyframes, fading linearly
// to each target on a slow tick, holding, then advancing or looping.
module led_fade_sequencer import led_pkg::*; #(
    parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter int TICK_HZ  = TICK_HZ_DEFAULT,
    parameter int DEPTH    = 8
) (
    input logic clk,
    input logic rst,
    led_fade_sequencer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_e          state_q;
    keyframe_t       tbl_q [DEPTH];
    keyframe_t       tgt_q;
    logic [AW-1:0]   idx_q;
    logic [AW:0]     cnt_q;
    logic [7:0]      step_q, hold_q, step_n, hold_n;
    logic [2:0][7:0] start_q, duty_q, tgt_rgb, lerp;
    logic            done_q, tick, last;

    // Clearing during LOAD puts the first FADE tick a full tick period later
    led_tick_gen #(.CYCLES(CLK_FREQ / TICK_HZ)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == LOAD),
        .tick_o (tick)
    );

    assign tgt_rgb = {tgt_q.blue, tgt_q.green, tgt_q.red};
    assign step_n  = step_q + 1'b1;
    assign hold_n  = hold_q + 1'b1;
    assign last    = {1'b0, idx_q} + 1'b1 >= cnt_q;

    always_comb
        for (int c = 0; c < 3; c++) lerp[c] = interp(start_q[c], tgt_rgb[c], step_n, tgt_q.fade);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            tbl_q   <= '{default: '0};
            tgt_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            step_q  <= '0;
            hold_q  <= '0;
            start_q <= '0;
            duty_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && bus.stop) state_q <= IDLE;
            else case (state_q)
                IDLE: begin
                    if (bus.wr_valid)
                        tbl_q[bus.wr_addr] <= {bus.wr_red, bus.wr_green, bus.wr_blue, bus.wr_fade, bus.wr_hold};
                    if (bus.start && bus.count != '0) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
                        cnt_q   <= bus.count;
                    end
                end
                LOAD: begin
                    start_q <= duty_q;
                    tgt_q   <= tbl_q[idx_q];
                    step_q  <= '0;
                    state_q <= FADE;
                end
                FADE:
                    if (tgt_q.fade == '0 || (tick && step_n == tgt_q.fade)) begin
                        duty_q  <= tgt_rgb;
                        hold_q  <= '0;
                        state_q <= HOLD;
                    end else if (tick) begin
                        duty_q <= lerp;
                        step_q <= step_n;
                    end
                HOLD:
                    if (tgt_q.hold == '0 || (tick && hold_n == tgt_q.hold)) begin
                        if (!last || bus.loop) begin
                            idx_q   <= last ? '0 : idx_q + 1'b1;
                            state_q <= LOAD;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (tick) hold_q <= hold_n;
            endcase
        end

    assign bus.wr_ready  = state_q == IDLE;
    assign bus.busy      = state_q != IDLE;
    assign bus.cur_index = idx_q;
    assign bus.seq_done  = done_q;
    assign {bus.blue_duty, bus.green_duty, bus.red_duty} = duty_q;

endmodule
